crc8_frame_arbiter: RTL and testbench

//  Shares one Crc8_Calculator instance between two frame-oriented requesters (0 = RX parser, 1 = TX builder).
//  - Grants the engine for one whole frame. Round-robin arbitration.
//  - Clears the CRC at frame start, streams bytes into it, and returns the final CRC with a done pulse.
//  - Aborts and releases the engine if the granted requester stalls too long mid-frame.
//  - Sits between the bridge's frame parser/builder and the CRC datapath.

---
 rtl/crc8_frame_arbiter.sv | 141 ++++++++++++++
 tb/tb_crc8_frame_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_frame_arbiter.sv
// Frame-granular round-robin arbiter that shares one CRC-8 calculator between
// the RX parser (requester 0) and the TX builder (requester 1).

module crc8_frame_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic sel,
    input  logic grant,
    input  logic rel,
    input  logic in_stream,
    input  logic in_done,
    input  logic in_abort,
    output logic gnt,
    output logic ready,
    output logic done,
    output logic abort
);
    always_ff @(posedge clk) begin
        if (!rst_n)     gnt <= 1'b0;
        else if (grant) gnt <= sel;
        else if (rel)   gnt <= 1'b0;
    end

    always_comb begin
        ready = gnt & in_stream;
        done  = gnt & in_done;
        abort = gnt & in_abort;
    end
endmodule

module crc8_frame_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_i,
    output logic [1:0]  gnt_o,
    input  logic [1:0]  byte_valid_i,
    input  logic [15:0] byte_data_i,
    input  logic [1:0]  byte_last_i,
    output logic [1:0]  byte_ready_o,
    output logic [7:0]  crc_result_o,
    output logic [1:0]  crc_done_o,
    output logic [1:0]  crc_abort_o,
    output logic        busy_o,
    output logic        calc_reset_o,
    output logic        calc_enable_o,
    output logic [7:0]  calc_data_o,
    input  logic [7:0]  calc_crc_i
);
    localparam int NUM_REQ = 2;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DONE, S_ABORT} state_t;

    state_t           state, state_nxt;
    logic             owner;
    logic             last_served;
    logic             pick;
    logic             accept, accept_last, timeout_hit;
    logic             set_gnt, rel_gnt;
    logic             st_stream, st_done, st_abort;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_inc;

    // grant is one-hot and held for the whole frame, so the upper bit names the owner
    assign owner = gnt_o[1];

    always_comb begin
        pick         = (req_i == 2'b11) ? ~last_served : req_i[1];
        accept       = (state == S_STREAM) & byte_valid_i[owner];
        accept_last  = accept & byte_last_i[owner];
        idle_cnt_inc = idle_cnt + 1'b1;
        timeout_hit  = (TIMEOUT_CYCLES != 0) && (state == S_STREAM) && !accept &&
                       (idle_cnt_inc == TO_LIM);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (|req_i) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_STREAM;
            S_STREAM: begin
                if (accept_last)      state_nxt = S_DONE;
                else if (timeout_hit) state_nxt = S_ABORT;
            end
            S_DONE:   state_nxt = S_IDLE;
            S_ABORT:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state != S_IDLE);
        calc_reset_o  = (state == S_CLEAR);
        calc_enable_o = accept;
        calc_data_o   = accept ? (owner ? byte_data_i[15:8] : byte_data_i[7:0]) : 8'h00;
        st_stream     = (state == S_STREAM);
        st_done       = (state == S_DONE);
        st_abort      = (state == S_ABORT);
        set_gnt       = (state == S_IDLE) & (|req_i);
        rel_gnt       = st_done | st_abort;
    end

    // stall counter only runs while streaming; an accepted byte always restarts it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt     <= '0;
            last_served  <= 1'b1;
            crc_result_o <= 8'h00;
        end else begin
            if (state == S_CLEAR || accept) idle_cnt <= '0;
            else if (state == S_STREAM)     idle_cnt <= idle_cnt_inc;
            if (accept_last) crc_result_o <= calc_crc_i;
            if (rel_gnt)     last_served  <= owner;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        localparam logic IDX = 1'(i);
        crc8_frame_lane u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .sel       (pick == IDX),
            .grant     (set_gnt),
            .rel       (rel_gnt),
            .in_stream (st_stream),
            .in_done   (st_done),
            .in_abort  (st_abort),
            .gnt       (gnt_o[i]),
            .ready     (byte_ready_o[i]),
            .done      (crc_done_o[i]),
            .abort     (crc_abort_o[i])
        );
    end
endmodule

// File: tb/tb_crc8_frame_arbiter.sv
// Scoreboard bench for crc8_frame_arbiter: two cycle-driven requesters, a CRC-8
// calculator model, and a monitor checking pulses, result and invariants.

module tb_crc8_frame_arbiter;
    localparam int TO = 16;

    typedef struct { logic [7:0] b; bit last; bit stall; int gap; } beat_t;
    typedef struct { bit abort; logic [7:0] crc; } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, vld = '0, lst = '0;
    logic [15:0] dat = '0;
    logic [1:0]  gnt, rdy, done, abrt;
    logic [7:0]  res, cdata, ccrc;
    logic [7:0]  calc_reg;
    logic        busy, creset, cen;

    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    beat_t bq [2][$];
    exp_t  expq [2][$];
    int   ph [2], gap_left [2], acc_cnt [2], req_cyc [2], lat [2];
    int   last_acc_cyc [2], done_cyc [2], abort_cyc [2];
    bit   acc [2];
    logic [7:0] model_res;
    bit   glog [$];
    int   gaps [$];
    logic [1:0] prev_gnt;
    int   idle_n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc8_frame_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt),
        .byte_valid_i(vld), .byte_data_i(dat), .byte_last_i(lst), .byte_ready_o(rdy),
        .crc_result_o(res), .crc_done_o(done), .crc_abort_o(abrt), .busy_o(busy),
        .calc_reset_o(creset), .calc_enable_o(cen), .calc_data_o(cdata), .calc_crc_i(ccrc)
    );

    // Crc8_Calculator stand-in: combinational next-CRC from a state register
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int k = 0; k < 8; k++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction
    assign ccrc = crc_step(calc_reg, cdata);
    always @(posedge clk) begin
        if (!rst_n || creset) calc_reg <= 8'h00;
        else if (cen)         calc_reg <= ccrc;
    end

    // Reference: remainder of M(x)*x^8 divided by x^8+x^2+x+1
    function automatic logic [7:0] crc8_ref(input logic [7:0] m[$]);
        logic [8:0] rem;
        int nb;
        bit b;
        rem = '0;
        nb = m.size() * 8;
        for (int k = 0; k < nb + 8; k++) begin
            b = (k < nb) ? m[k / 8][7 - (k % 8)] : 1'b0;
            rem = {rem[7:0], b};
            if (rem[8]) rem = rem ^ 9'h107;
        end
        return rem[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_frame(input bit r, input logic [7:0] m[$], input int maxgap,
                             input bit abort_end, input int exp_crc);
        beat_t bt;
        exp_t e;
        foreach (m[k]) begin
            bt.b = m[k];
            bt.last = !abort_end && (k == m.size() - 1);
            bt.stall = 1'b0;
            bt.gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            bq[r].push_back(bt);
        end
        if (abort_end) begin
            bt.b = 8'h00; bt.last = 1'b0; bt.stall = 1'b1; bt.gap = 0;
            bq[r].push_back(bt);
        end
        e.abort = abort_end;
        e.crc = (exp_crc >= 0) ? 8'(exp_crc) : crc8_ref(m);
        expq[r].push_back(e);
    endtask

    task automatic set_dat(input bit r, input logic [7:0] v);
        if (r) dat[15:8] = v;
        else   dat[7:0]  = v;
    endtask

    task automatic step(input bit r);
        beat_t bt;
        if (ph[r] == 2) begin
            if (acc[r]) begin
                bt = bq[r].pop_front();
                acc_cnt[r]++;
                last_acc_cyc[r] = cyc;
                if (bt.last) begin
                    chk("ready_drop_after_last", rdy[r], 0);
                    ph[r] = 0;
                end else if (bq[r].size() > 0) gap_left[r] = bq[r][0].gap;
            end else if (bq[r][0].stall && !gnt[r]) begin
                bt = bq[r].pop_front();
                ph[r] = 0;
            end
        end
        if (ph[r] == 1 && gnt[r]) begin
            req[r] = 1'b0;
            ph[r] = 2;
            lat[r] = cyc - req_cyc[r];
            gap_left[r] = bq[r][0].gap;
        end
        if (ph[r] == 0 && bq[r].size() > 0) begin
            req[r] = 1'b1;
            ph[r] = 1;
            req_cyc[r] = cyc;
        end
        if (ph[r] == 2 && !bq[r][0].stall && gap_left[r] == 0) begin
            vld[r] = 1'b1;
            lst[r] = bq[r][0].last;
            set_dat(r, bq[r][0].b);
        end else begin
            vld[r] = 1'b0;
            lst[r] = 1'b0;
            set_dat(r, 8'h00);
            if (ph[r] == 2 && gap_left[r] > 0) gap_left[r]--;
        end
    endtask

    task automatic run(input int budget, input int stop_acc0);
        int n;
        n = 0;
        while (n < budget) begin
            if (stop_acc0 > 0 && acc_cnt[0] >= stop_acc0) break;
            if (ph[0] == 0 && ph[1] == 0 && bq[0].size() == 0 && bq[1].size() == 0 &&
                expq[0].size() == 0 && expq[1].size() == 0) break;
            @(negedge clk);
            acc[0] = vld[0] & rdy[0];
            acc[1] = vld[1] & rdy[1];
            @(posedge clk); #1;
            n++;
            step(1'b0);
            step(1'b1);
        end
        chk("run_budget_expired", n >= budget, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req = '0; vld = '0; lst = '0; dat = '0;
        for (int k = 0; k < 2; k++) begin
            bq[k].delete(); expq[k].delete();
            ph[k] = 0; gap_left[k] = 0; acc_cnt[k] = 0;
        end
        model_res = 8'h00;
        prev_gnt = '0;
        glog.delete(); gaps.delete();
        @(posedge clk); #1;
        chk("reset_outputs", {gnt, rdy, done, abrt, res, busy, creset, cen, cdata}, 0);
        rst_n = 1'b1;
    endtask

    task automatic mon_lane(input bit r);
        exp_t e;
        if (done[r] || abrt[r]) begin
            if (expq[r].size() == 0) chk("unexpected_pulse", {done[r], abrt[r]}, 0);
            else begin
                e = expq[r].pop_front();
                chk("pulse_kind", abrt[r], e.abort);
                if (!e.abort) begin
                    model_res = e.crc;
                    chk("crc_value", res, e.crc);
                    done_cyc[r] = cyc;
                end else begin
                    chk("abort_keeps_crc", res, model_res);
                    abort_cyc[r] = cyc;
                end
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon_lane(1'b0);
                mon_lane(1'b1);
                chk("crc_result_hold", res, model_res);
                chk("busy_vs_gnt", busy, |gnt);
                chk("gnt_onehot", $countones(gnt) > 1, 0);
                chk("ready_owner", rdy & ~gnt, 0);
                chk("ready_in_clear", rdy & {2{creset}}, 0);
                chk("pulse_owner", (done | abrt) & ~gnt, 0);
                chk("calc_reset", creset, (gnt != 0) && (prev_gnt == 0));
                chk("calc_enable", cen, |(vld & rdy));
                chk("calc_data", cdata, cen ? (gnt[1] ? dat[15:8] : dat[7:0]) : 8'h00);
                if (gnt != 0 && prev_gnt == 0) begin
                    glog.push_back(gnt[1]);
                    gaps.push_back(idle_n);
                end
                idle_n = (gnt == 0) ? idle_n + 1 : 0;
                prev_gnt = gnt;
            end
        end
    endtask

    initial begin
        logic [7:0] s9[$];
        logic [7:0] q[$];
        int len;
        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        model_res = 8'h00;
        prev_gnt = '0;
        idle_n = 0;
        fork monitor(); join_none

        // check string frame, grant latency, done timing
        do_reset();
        add_frame(1'b0, s9, 0, 1'b0, 'hF4);
        run(500, 0);
        chk("gnt_latency", lat[0], 1);
        chk("done_delay", done_cyc[0] - last_acc_cyc[0], 0);

        // one-byte frames on requester 1
        q = '{8'h01}; add_frame(1'b1, q, 0, 1'b0, 'h07);
        q = '{8'h00}; add_frame(1'b1, q, 0, 1'b0, 'h00);
        run(500, 0);

        // simultaneous requests alternate 0,1,0,1 with one idle cycle between frames
        do_reset();
        for (int k = 0; k < 2; k++) begin
            q = '{8'($urandom), 8'($urandom), 8'($urandom)};
            add_frame(1'b0, q, 2, 1'b0, -1);
            q = '{8'($urandom), 8'($urandom)};
            add_frame(1'b1, q, 2, 1'b0, -1);
        end
        run(1000, 0);
        chk("grant_count", glog.size(), 4);
        if (glog.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("grant_order", glog[k], k % 2);
            chk("idle_gap", gaps[1], 1);
        end

        // CLEAR isolates consecutive frames
        q = '{8'hFF}; add_frame(1'b0, q, 0, 1'b0, 'hF3);
        run(500, 0);
        add_frame(1'b1, s9, 0, 1'b0, 'hF4);
        run(500, 0);

        // timeout abort releases the engine to the pending requester
        glog.delete(); gaps.delete();
        q = '{8'hA5, 8'h3C}; add_frame(1'b0, q, 0, 1'b1, 0);
        q = '{8'h10, 8'h20, 8'h30}; add_frame(1'b1, q, 1, 1'b0, -1);
        run(1000, 0);
        chk("abort_delay", abort_cyc[0] - last_acc_cyc[0], TO);
        chk("abort_grant_count", glog.size(), 2);
        if (glog.size() == 2) chk("after_abort_grant", glog[1], 1);

        // reset mid-frame drops the frame silently, then a fresh frame works
        for (int k = 0; k < 2; k++) acc_cnt[k] = 0;
        add_frame(1'b0, s9, 0, 1'b0, 'hF4);
        run(500, 4);
        chk("mid_frame_bytes", acc_cnt[0], 4);
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        add_frame(1'b0, s9, 1, 1'b0, 'hF4);
        run(500, 0);

        // randomized traffic against the reference
        for (int round = 0; round < 8; round++) begin
            for (int r = 0; r < 2; r++) begin
                repeat ($urandom_range(3, 0)) begin
                    q.delete();
                    len = $urandom_range(8, 1);
                    repeat (len) q.push_back(8'($urandom));
                    add_frame(r[0], q, 3, $urandom_range(5, 0) == 0, -1);
                end
            end
            run(5000, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
